// File: rtl/wb_initiator_pkg.sv
// Shared types and defaults for the Wishbone classic single-transfer initiator.
package wb_initiator_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int          DEFAULT_TIMEOUT   = 64;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;
  localparam logic [7:0]  TCNT_MAX          = 8'hFF;
endpackage

// File: rtl/wb_initiator.sv
// Turns a valid/ready command stream into Wishbone classic cycles, one at a time,
// aborting any cycle that is not acknowledged within TIMEOUT cycles.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int          TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int          TIMEOUT_W = 8,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic        io_wbs_clk,
  input  logic        io_wbs_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [31:0] io_wbs_adr,
  output logic [31:0] io_wbs_datwr,
  input  logic [31:0] io_wbs_datrd,
  output logic        io_wbs_we,
  output logic        io_wbs_stb,
  output logic        io_wbs_cyc,
  input  logic        io_wbs_ack,
  output logic [7:0]  timeout_cnt
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic [TIMEOUT_W-1:0] wait_reg, wait_next;
  logic [31:0]          adr_reg, adr_next;
  logic [31:0]          datwr_reg, datwr_next;
  logic                 we_reg, we_next;
  logic                 cyc_reg, cyc_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic [31:0]          rsp_dat_reg, rsp_dat_next;
  logic                 rsp_err_reg, rsp_err_next;
  logic [7:0]           tcnt_reg, tcnt_next;

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state_reg     <= IDLE;
      wait_reg      <= '0;
      adr_reg       <= '0;
      datwr_reg     <= '0;
      we_reg        <= 1'b0;
      cyc_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_err_reg   <= 1'b0;
      tcnt_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      wait_reg      <= wait_next;
      adr_reg       <= adr_next;
      datwr_reg     <= datwr_next;
      we_reg        <= we_next;
      cyc_reg       <= cyc_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_dat_reg   <= rsp_dat_next;
      rsp_err_reg   <= rsp_err_next;
      tcnt_reg      <= tcnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_next      = wait_reg;
    adr_next       = adr_reg;
    datwr_next     = datwr_reg;
    we_next        = we_reg;
    cyc_next       = cyc_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_dat_next   = rsp_dat_reg;
    rsp_err_next   = rsp_err_reg;
    tcnt_next      = tcnt_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          adr_next   = req_adr;
          datwr_next = req_dat;
          we_next    = req_we;
          cyc_next   = 1'b1;
          wait_next  = '0;
          state_next = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so a late ack on the last allowed cycle still succeeds.
        if (io_wbs_ack) begin
          cyc_next       = 1'b0;
          we_next        = 1'b0;
          rsp_dat_next   = we_reg ? 32'h0 : io_wbs_datrd;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (wait_reg == WAIT_LAST) begin
          cyc_next       = 1'b0;
          we_next        = 1'b0;
          rsp_dat_next   = we_reg ? 32'h0 : ERR_RDATA;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          tcnt_next      = (tcnt_reg == TCNT_MAX) ? tcnt_reg : tcnt_reg + 8'd1;
          state_next     = RESP;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready    = (state_reg == IDLE);
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_dat      = rsp_dat_reg;
  assign rsp_err      = rsp_err_reg;
  assign io_wbs_adr   = adr_reg;
  assign io_wbs_datwr = datwr_reg;
  assign io_wbs_we    = we_reg;
  assign io_wbs_cyc   = cyc_reg;
  assign io_wbs_stb   = cyc_reg;
  assign timeout_cnt  = tcnt_reg;

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
Wishbone classic single-transfer initiator that turns a valid/ready command stream into bus cycles toward the address-decoding Wishbone mux. It drives io_wbs_* master signals and waits for ack. A timeout counter aborts a cycle that no peripheral acknowledges. Used by on-chip sequencers and test logic that program waveform-generator peripherals without the management core.

Parameters:
TIMEOUT, 64, cycles stb may stay high without ack before abort (1..2**TIMEOUT_W-1)
TIMEOUT_W, 8, width of timeout counter
ERR_RDATA, 32'hDEADBEEF, read data returned on timeout

Ports:
io_wbs_clk  input  1  clock
io_wbs_rst  input  1  synchronous active-high reset
req_valid  input  1  command valid
req_ready  output  1  command accepted when valid&ready
req_we  input  1  1=write, 0=read
req_adr  input  32  byte address
req_dat  input  32  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when valid&ready
rsp_dat  output  32  read data (0 for writes)
rsp_err  output  1  1=timed out
io_wbs_adr  output  32  WB address
io_wbs_datwr  output  32  WB write data
io_wbs_datrd  input  32  WB read data
io_wbs_we  output  1  WB write enable
io_wbs_stb  output  1  WB strobe
io_wbs_cyc  output  1  WB cycle
io_wbs_ack  input  1  WB acknowledge
timeout_cnt  output  8  saturating count of aborted cycles

Behaviour:
- Single clock io_wbs_clk; synchronous active-high io_wbs_rst. All outputs except req_ready are registered.
- Reset values: io_wbs_cyc/stb/we=0, io_wbs_adr/datwr=0, rsp_valid=0, rsp_dat=0, rsp_err=0, timeout_cnt=0, state=IDLE.
- FSM states IDLE, BUS, RESP.
- IDLE:
  - req_ready=1 (combinational, state==IDLE only).
  - On req_valid: latch req_adr/req_dat/req_we into io_wbs_adr/datwr/we; set cyc=stb=1; clear wait counter; go BUS.
  - Accept edge = cycle 0; stb high from cycle 1.
- BUS:
  - cyc=stb=1; adr/datwr/we held stable.
  - Wait counter increments each cycle without ack.
  - If io_wbs_ack: clear cyc/stb/we at next edge; rsp_dat=io_wbs_datrd for reads, 0 for writes; rsp_err=0; rsp_valid=1; go RESP.
  - Ack sampled in cycle k gives rsp_valid in cycle k+1. Zero-wait peripheral: ack in cycle 1, rsp_valid in cycle 2.
  - Else, if wait counter == TIMEOUT-1: clear cyc/stb/we; rsp_dat=ERR_RDATA for reads, 0 for writes; rsp_err=1; rsp_valid=1; timeout_cnt+=1, saturating at 255; go RESP.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP:
  - rsp_valid/rsp_dat/rsp_err held until rsp_ready.
  - On rsp_ready: rsp_valid=0, go IDLE.
  - Next command accepted no earlier than the following cycle, so back-to-back commands take at least 3 cycles each.
- io_wbs_ack outside BUS is ignored; no state change.
- io_wbs_adr/datwr keep the last value when idle. Only cyc/stb qualify them.
- Reset mid-BUS: cyc/stb low at the next edge; pending response discarded; timeout_cnt cleared.
- Only one outstanding transfer. No pipelined or burst mode.

Decomposition:
- Package wb_initiator_pkg: state enum typedef (IDLE, BUS, RESP), default TIMEOUT constant, ERR_RDATA constant.
- No sub-module. The wait counter and the saturating timeout counter stay inline.

Test Plan:
- Write, zero-wait ack: req adr=0x30000004 dat=0x000000A5 we=1 -> cyc/stb high in cycle 1 with adr/datwr stable; ack in cycle 1 -> rsp_valid cycle 2, rsp_err=0, rsp_dat=0, cyc low cycle 2.
- Read, 3-wait ack: req adr=0x30001010 we=0; peripheral acks in cycle 4 with datrd=0x12345678 -> rsp_dat=0x12345678, rsp_valid cycle 5.
- Timeout: TIMEOUT=4, read adr=0x40000000, no ack -> stb high cycles 1-4, low cycle 5; rsp_err=1, rsp_dat=0xDEADBEEF; timeout_cnt=1.
- Ack on the final timeout cycle: TIMEOUT=4, ack in cycle 4 -> rsp_err=0, timeout_cnt unchanged.
- Backpressure: rsp_ready low 5 cycles -> rsp fields stable, req_ready=0 and new req_valid ignored; after rsp_ready, the next command is accepted the following cycle.
- Reset in BUS cycle 2 -> cyc/stb=0 next edge, rsp_valid=0, timeout_cnt=0; 256 forced timeouts saturate timeout_cnt at 255.
